// File: rtl/spike_fifo_scheduler_pkg.sv
// Shared types and constants for the spike FIFO scheduler.
package spike_sched_pkg;

  // Drain-side state machine encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } drain_state_e;

  // Width of the burst read counter (BURST_MAX is limited to 15).
  localparam int BCNT_W = 4;

  // Width of an encoded requester index; at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_fifo_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: searches upward from the port
// after the previous winner, wrapping modulo NUM_REQ.
module rr_arbiter
  import spike_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // w_cand[k] is the port examined k-th: last_grant+1+k modulo NUM_REQ.
  logic [IDX_W-1:0] w_cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_cand[gi] = IDX_W'((32'(i_last_grant) + gi + 1) % NUM_REQ);
    end
  endgenerate

  // First requesting port in rotated priority order wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_enable && !o_valid && i_req[w_cand[k]]) begin
        o_valid           = 1'b1;
        o_gnt[w_cand[k]]  = 1'b1;
        o_idx             = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/spike_fifo_scheduler.sv
// Shares one spike FIFO among several requesters (round-robin write side)
// and paces its drain toward the router (burst-limited read side).
module spike_fifo_scheduler
  import spike_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 12,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_afull,
  input  logic                          i_fifo_empty,
  output logic                          o_fifo_rd_en,
  input  logic                          i_out_ready,
  output logic                          o_out_valid,
  output logic                          o_burst_active
);

  localparam int IDX_W = idx_width(NUM_REQ);

  // Write side registers.
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [IDX_W-1:0]      r_last_grant;

  // Drain side registers.
  drain_state_e          r_state;
  drain_state_e          w_state_next;
  logic [BCNT_W-1:0]     r_burst_cnt;
  logic [BCNT_W-1:0]     w_burst_cnt_next;
  logic                  r_out_valid;
  logic                  r_burst_active;

  logic                  w_permit;
  logic                  w_grant_valid;
  logic [IDX_W-1:0]      w_grant_idx;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_rd_en;

  // A write already in flight plus an almost-full FIFO would overflow on the
  // next write, so the grant waits a cycle. Gating with rst_n keeps gnt low
  // while reset is held.
  assign w_permit = rst_n & ~i_fifo_full & ~(r_wr_en & i_fifo_afull);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req        (i_req),
    .i_last_grant (r_last_grant),
    .i_enable     (w_permit),
    .o_gnt        (o_gnt),
    .o_idx        (w_grant_idx),
    .o_valid      (w_grant_valid)
  );

  assign w_win_data = i_req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];

  // Register the winner's packet into the FIFO write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_wr_en <= w_grant_valid;
      if (w_grant_valid) begin
        r_wr_data    <= w_win_data;
        r_last_grant <= w_grant_idx;
      end
    end
  end

  assign o_fifo_wr_en   = r_wr_en;
  assign o_fifo_wr_data = r_wr_data;

  // Drain FSM next state, burst count and read strobe.
  always_comb begin
    w_state_next     = r_state;
    w_burst_cnt_next = r_burst_cnt;
    w_rd_en          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_fifo_empty && i_out_ready) w_state_next = BURST;
      end
      BURST: begin
        w_rd_en = ~i_fifo_empty & i_out_ready;
        if (w_rd_en) begin
          if (r_burst_cnt == BCNT_W'(BURST_MAX - 1)) begin
            w_state_next     = GAP;
            w_burst_cnt_next = '0;
          end else begin
            w_burst_cnt_next = r_burst_cnt + 1'b1;
          end
        end else if (i_fifo_empty) begin
          w_state_next     = IDLE;
          w_burst_cnt_next = '0;
        end
        // Downstream stall with data waiting: hold state and count.
      end
      GAP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next     = IDLE;
        w_burst_cnt_next = '0;
      end
    endcase
  end

  // Drain FSM state, count and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_burst_cnt    <= '0;
      r_out_valid    <= 1'b0;
      r_burst_active <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_burst_cnt    <= w_burst_cnt_next;
      r_out_valid    <= w_rd_en;
      r_burst_active <= (w_state_next == BURST);
    end
  end

  assign o_fifo_rd_en   = w_rd_en;
  assign o_out_valid    = r_out_valid;
  assign o_burst_active = r_burst_active;

endmodule

// File: tb/tb_spike_fifo_scheduler.sv
// Directed self-checking bench for spike_fifo_scheduler.
module tb_spike_fifo_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 12;
  localparam int BURST_MAX  = 4;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          fifo_afull;
  logic                          fifo_empty;
  logic                          fifo_rd_en;
  logic                          out_ready;
  logic                          out_valid;
  logic                          burst_active;

  int n_cmp  = 0;
  int n_fail = 0;

  spike_fifo_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_MAX  (BURST_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (req),
    .i_req_data     (req_data),
    .o_gnt          (gnt),
    .o_fifo_wr_en   (fifo_wr_en),
    .o_fifo_wr_data (fifo_wr_data),
    .i_fifo_full    (fifo_full),
    .i_fifo_afull   (fifo_afull),
    .i_fifo_empty   (fifo_empty),
    .o_fifo_rd_en   (fifo_rd_en),
    .i_out_ready    (out_ready),
    .o_out_valid    (out_valid),
    .o_burst_active (burst_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_g [5] = '{1, 2, 4, 8, 1};
  int exp_d [5] = '{12'hA00, 12'hA01, 12'hA02, 12'hA03, 12'hA00};
  int rd_pat [16] = '{0,1,1,1,1,0,0,1,1,1,1,0,0,1,1,0};
  int ba_pat [16] = '{0,1,1,1,1,0,0,1,1,1,1,0,0,1,1,1};
  int st_rdy [10] = '{1,1,1,0,0,0,1,1,1,1};
  int st_rd  [10] = '{0,1,1,0,0,0,1,1,0,0};
  int st_ba  [10] = '{0,1,1,1,1,1,1,1,0,0};

  initial begin
    int pkts;
    int prev_rd;
    logic rd_seen;

    rst_n      = 1'b0;
    req        = '0;
    req_data   = {12'hA03, 12'hA02, 12'hA01, 12'hA00};
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    fifo_empty = 1'b1;
    out_ready  = 1'b0;

    // Reset state, with requests present to show gnt is held low.
    #12;
    req = 4'b1111;
    #1;
    check("rst_gnt",      32'(gnt), 0);
    check("rst_wr_en",    32'(fifo_wr_en), 0);
    check("rst_wr_data",  32'(fifo_wr_data), 0);
    check("rst_rd_en",    32'(fifo_rd_en), 0);
    check("rst_out_valid",32'(out_valid), 0);
    check("rst_burst",    32'(burst_active), 0);
    tick();
    rst_n = 1'b1;

    // Round robin over all four ports: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("rr_gnt[%0d]", i), 32'(gnt), 32'(exp_g[i]));
      tick();
      check($sformatf("rr_wr_en[%0d]", i), 32'(fifo_wr_en), 1);
      check($sformatf("rr_wr_data[%0d]", i), 32'(fifo_wr_data), 32'(exp_d[i]));
    end
    req = '0;
    tick();
    check("idle_wr_en", 32'(fifo_wr_en), 0);

    // FIFO full blocks port 2 for five cycles.
    req       = 4'b0100;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("full_gnt[%0d]", i), 32'(gnt), 0);
      tick();
      check($sformatf("full_wr_en[%0d]", i), 32'(fifo_wr_en), 0);
    end
    fifo_full = 1'b0;
    #2;
    check("unfull_gnt", 32'(gnt), 32'h4);
    tick();
    check("unfull_wr_en", 32'(fifo_wr_en), 1);
    check("unfull_wr_data", 32'(fifo_wr_data), 32'hA02);

    // Almost full with a write pending: one cycle stall, then port 0.
    req        = 4'b0011;
    fifo_afull = 1'b1;
    #2;
    check("afull_gnt_block", 32'(gnt), 0);
    tick();
    check("afull_wr_en_drop", 32'(fifo_wr_en), 0);
    #1;
    check("afull_gnt_p0", 32'(gnt), 32'h1);
    tick();
    check("afull_wr_data", 32'(fifo_wr_data), 32'hA00);
    fifo_afull = 1'b0;
    #1;
    check("afull_clear_gnt_p1", 32'(gnt), 32'h2);
    tick();
    check("afull_clear_wr_data", 32'(fifo_wr_data), 32'hA01);
    req = '0;
    tick();

    // Drain ten packets with downstream always ready.
    pkts      = 10;
    out_ready = 1'b1;
    prev_rd   = 0;
    for (int i = 0; i < 16; i++) begin
      fifo_empty = (pkts == 0);
      #2;
      rd_seen = fifo_rd_en;
      check($sformatf("drain_rd[%0d]", i), 32'(fifo_rd_en), 32'(rd_pat[i]));
      check($sformatf("drain_ov[%0d]", i), 32'(out_valid), 32'(prev_rd));
      check($sformatf("drain_ba[%0d]", i), 32'(burst_active), 32'(ba_pat[i]));
      prev_rd = rd_pat[i];
      tick();
      if (rd_seen && pkts > 0) pkts--;
    end
    fifo_empty = 1'b1;
    #2;
    check("drain_end_ba", 32'(burst_active), 0);
    check("drain_end_pkts", 32'(pkts), 0);

    // Downstream stall after two reads of a burst.
    pkts = 6;
    for (int i = 0; i < 10; i++) begin
      fifo_empty = (pkts == 0);
      out_ready  = st_rdy[i][0];
      #2;
      rd_seen = fifo_rd_en;
      check($sformatf("stall_rd[%0d]", i), 32'(fifo_rd_en), 32'(st_rd[i]));
      check($sformatf("stall_ba[%0d]", i), 32'(burst_active), 32'(st_ba[i]));
      tick();
      if (rd_seen && pkts > 0) pkts--;
    end
    fifo_empty = 1'b1;
    tick();
    tick();

    // Asynchronous reset while bursting with a write pending.
    fifo_empty = 1'b0;
    out_ready  = 1'b1;
    req        = 4'b0010;
    #2;
    check("pre_rst_gnt", 32'(gnt), 32'h2);
    tick();
    check("pre_rst_wr_en", 32'(fifo_wr_en), 1);
    check("pre_rst_burst", 32'(burst_active), 1);
    check("pre_rst_rd_en", 32'(fifo_rd_en), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt",       32'(gnt), 0);
    check("mid_rst_wr_en",     32'(fifo_wr_en), 0);
    check("mid_rst_wr_data",   32'(fifo_wr_data), 0);
    check("mid_rst_rd_en",     32'(fifo_rd_en), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_burst",     32'(burst_active), 0);
    tick();
    rst_n      = 1'b1;
    req        = 4'b1111;
    fifo_empty = 1'b1;
    #2;
    check("post_rst_gnt", 32'(gnt), 32'h1);
    tick();
    check("post_rst_wr_data", 32'(fifo_wr_data), 32'hA00);
    req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_fifo_scheduler.md
# spike_fifo_scheduler

Single-clock controller that shares one spike-packet FIFO between several local spike sources and paces its drain toward the router. Write side: round-robin arbitration of up to NUM_REQ requesters into the FIFO write port with full/almost-full back-pressure. Read side: burst-limited drain FSM that issues FIFO read enables while downstream is ready, inserting a gap cycle after each maximum-length burst. It sits between the neuron-core spike outputs and the node's spike FIFO / router injection port.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 12: spike packet width.
- BURST_MAX, 4: maximum consecutive FIFO reads before a forced gap cycle (1..15).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester packet-valid; held until granted.
- req_data  in  NUM_REQ*DATA_WIDTH  packed packets, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot, combinational grant; the requester's packet is accepted at the rising edge where gnt[i]=1.
- fifo_wr_en  out  1  registered FIFO write strobe.
- fifo_wr_data  out  DATA_WIDTH  registered FIFO write data.
- fifo_full  in  1  FIFO has no free slot.
- fifo_afull  in  1  FIFO has at most one free slot.
- fifo_empty  in  1  FIFO holds no packet.
- fifo_rd_en  out  1  FIFO read strobe (combinational from state and inputs).
- out_ready  in  1  router injection port can accept a packet.
- out_valid  out  1  registered; high the cycle after fifo_rd_en (FIFO read latency is one cycle).
- burst_active  out  1  registered; high while the drain FSM is in BURST.

## Operation
- Reset: gnt=0, fifo_wr_en=0, fifo_wr_data=0, fifo_rd_en=0, out_valid=0, burst_active=0, last_grant=NUM_REQ-1 (port 0 has first priority), burst_cnt=0, state IDLE. Reset mid-operation discards any pending write; no partial grant survives.
- Grant permitted in a cycle iff fifo_full=0 and not (fifo_wr_en=1 and fifo_afull=1).
- When permitted and req≠0: grant the first requester with req set, searching from last_grant+1 upward with wrap-around modulo NUM_REQ. At that edge: fifo_wr_data←winner's data, fifo_wr_en←1, last_grant←winner.
- When not permitted or req=0: gnt=0, fifo_wr_en←0 at the next edge, last_grant unchanged.
- Exactly one grant per cycle at most; back-to-back grants to different ports give one write per cycle.
- Drain FSM states:
  - IDLE: fifo_rd_en=0; go to BURST when fifo_empty=0 and out_ready=1.
  - BURST: fifo_rd_en = ~fifo_empty & out_ready. Each asserted read increments burst_cnt. Transitions:
    - Read with burst_cnt=BURST_MAX-1 → GAP, burst_cnt←0.
    - fifo_empty=1 → IDLE, burst_cnt←0.
    - out_ready=0 → stay in BURST, count held.
  - GAP: fifo_rd_en=0 for exactly one cycle, then IDLE.
- Simultaneous write and read in one cycle is legal; the two sides are independent except through the FIFO flags.

## Timing
- Write latency: gnt in cycle t → fifo_wr_en/fifo_wr_data valid in cycle t+1.
- Read latency: fifo_rd_en in cycle t → out_valid in cycle t+1.
- Minimum read-to-read restart after a full burst: BURST_MAX reads, 1 GAP cycle, 1 IDLE cycle.
- The afull rule prevents overflow from the registered write stage; FIFO flags are assumed valid in the same cycle they are sampled.

## Structure
- Package spike_sched_pkg holds:
  - drain-state enum {IDLE, BURST, GAP};
  - localparam widths for the grant index ($clog2(NUM_REQ)) and burst_cnt (4 bits).
- One sub-module, rr_arbiter: combinational rotating-priority pick (req, last_grant, enable) → one-hot gnt plus encoded index.
- The top level holds the write register, last_grant, and the drain FSM.

## Test plan
- Reset then all req=4'b1111, FIFO never full → gnt sequence 0,1,2,3,0; fifo_wr_data matches each port's data one cycle later.
- req=4'b0100 held while fifo_full=1 for 5 cycles → gnt=0, fifo_wr_en=0; on full falling → gnt=4'b0100 next cycle, write follows.
- Write pending with fifo_afull=1 and req=4'b0011 → no grant that cycle; grant port 0 the following cycle after fifo_wr_en drops.
- FIFO holds 10 packets, out_ready=1, BURST_MAX=4 → rd_en pattern 1111 0 0 1111 0 0 11; out_valid mirrors it delayed by one cycle.
- out_ready dropped mid-burst after 2 reads for 3 cycles → rd_en=0 during the stall; 2 more reads follow, then GAP.
- rst_n asserted while in BURST with fifo_wr_en=1 → all outputs 0 immediately; the next grant after release goes to port 0.
